// File: rtl/seven_segment_display_mux.sv
// Time-multiplexed hex driver for a common-segment display with tear-free update handshake,
// leading-zero blanking, PWM brightness and per-digit dots. Optional blink: SEVEN_SEGMENT_DISPLAY_MUX_BLINK_EN.
module seven_segment_display_mux #(
  parameter int clk_mhz   = 50,
  parameter int w_digit   = 8,
  parameter int update_hz = 120,
  parameter int w_bright  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*w_digit-1:0]   number,
  input  logic [w_digit-1:0]     dots,
  input  logic                   number_valid,
  output logic                   number_ready,
  input  logic                   blank_lz,
  input  logic [w_bright-1:0]    brightness,
`ifdef SEVEN_SEGMENT_DISPLAY_MUX_BLINK_EN
  input  logic [w_digit-1:0]     blink,
`endif
  output logic [7:0]             abcdefgh,
  output logic [w_digit-1:0]     digit
);

  localparam int SLOT_RAW = (clk_mhz * 1_000_000) / (update_hz * w_digit);
  localparam int P        = (SLOT_RAW < 1) ? 1 : SLOT_RAW;
  localparam int DIV_W    = (P > 1) ? $clog2(P) : 1;
  localparam int IDX_W    = (w_digit > 1) ? $clog2(w_digit) : 1;

  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    case (nib)
      4'h0: decode_hex = 7'b1111110;
      4'h1: decode_hex = 7'b0110000;
      4'h2: decode_hex = 7'b1101101;
      4'h3: decode_hex = 7'b1111001;
      4'h4: decode_hex = 7'b0110011;
      4'h5: decode_hex = 7'b1011011;
      4'h6: decode_hex = 7'b1011111;
      4'h7: decode_hex = 7'b1110000;
      4'h8: decode_hex = 7'b1111111;
      4'h9: decode_hex = 7'b1111011;
      4'hA: decode_hex = 7'b1110111;
      4'hB: decode_hex = 7'b0011111;
      4'hC: decode_hex = 7'b1001110;
      4'hD: decode_hex = 7'b0111101;
      4'hE: decode_hex = 7'b1001111;
      default: decode_hex = 7'b1000111;
    endcase
  endfunction

  logic [DIV_W-1:0]     div_p0;
  logic [IDX_W-1:0]     idx_p0;
  logic [w_bright-1:0]  pwm_p0;
  logic                 tc_p0;
  logic                 last_idx_p0;
  logic                 frame_p0;

  logic [4*w_digit-1:0] disp_num;
  logic [w_digit-1:0]   disp_dots;
  logic [4*w_digit-1:0] pend_num;
  logic [w_digit-1:0]   pend_dots;
  logic                 pend_full;

  logic [3:0]           cur_nib;
  logic                 cur_dot;
  logic                 cur_blank;
  logic                 cur_blink;
  logic                 zero_run;
  logic [w_digit-1:0]   blank_vec;
  logic [6:0]           seg_p0;
  logic [7:0]           abc_nxt;
  logic [w_digit-1:0]   digit_nxt;
  logic                 blink_phase;

  assign tc_p0        = (div_p0 == DIV_W'(P - 1));
  assign last_idx_p0  = (idx_p0 == IDX_W'(w_digit - 1));
  assign frame_p0     = tc_p0 & last_idx_p0;
  assign number_ready = ~pend_full;

  // Stage p0: slot divider, scan index and free-running PWM counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_p0 <= '0;
      idx_p0 <= '0;
      pwm_p0 <= '0;
    end else begin
      div_p0 <= tc_p0 ? '0 : div_p0 + 1'b1;
      if (tc_p0)
        idx_p0 <= last_idx_p0 ? '0 : idx_p0 + 1'b1;
      pwm_p0 <= pwm_p0 + 1'b1;
    end
  end

  // Pending slot holds one update until the frame wraps, so a frame never mixes old and new digits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_num  <= '0;
      disp_dots <= '0;
      pend_num  <= '0;
      pend_dots <= '0;
      pend_full <= 1'b0;
    end else begin
      if (frame_p0 && pend_full) begin
        disp_num  <= pend_num;
        disp_dots <= pend_dots;
        pend_full <= 1'b0;
      end else if (number_valid && !pend_full) begin
        pend_num  <= number;
        pend_dots <= dots;
        pend_full <= 1'b1;
      end
    end
  end

`ifdef SEVEN_SEGMENT_DISPLAY_MUX_BLINK_EN
  localparam int BLINK_CNT = (clk_mhz * 250_000 < 1) ? 1 : clk_mhz * 250_000;
  localparam int BLINK_W   = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
  logic [BLINK_W-1:0] blink_tmr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_tmr   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_tmr == BLINK_W'(BLINK_CNT - 1)) begin
      blink_tmr   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_tmr   <= blink_tmr + 1'b1;
    end
  end
`else
  assign blink_phase = 1'b0;
`endif

  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    cur_nib   = '0;
    cur_dot   = 1'b0;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    zero_run  = 1'b1;
    blank_vec = '0;
    digit_nxt = '0;
    for (int i = w_digit - 1; i >= 0; i--) begin
      zero_run = zero_run & (disp_num[4*i +: 4] == 4'h0);
      if (i != 0)
        blank_vec[i] = zero_run;
    end
    for (int i = 0; i < w_digit; i++) begin
      if (idx_p0 == IDX_W'(i)) begin
        cur_nib      = disp_num[4*i +: 4];
        cur_dot      = disp_dots[i];
        cur_blank    = blank_vec[i];
        digit_nxt[i] = 1'b1;
`ifdef SEVEN_SEGMENT_DISPLAY_MUX_BLINK_EN
        cur_blink    = blink[i];
`endif
      end
    end
    seg_p0  = decode_hex(cur_nib);
    abc_nxt = {(blank_lz && cur_blank) ? 7'b0 : seg_p0, cur_dot};
    if (pwm_p0 > brightness)
      abc_nxt = 8'h00;
    if (blink_phase && cur_blink)
      abc_nxt = 8'h00;
  end

  // Stage p1: registered pin drivers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      abcdefgh <= 8'h00;
      digit    <= '0;
    end else begin
      abcdefgh <= abc_nxt;
      digit    <= digit_nxt;
    end
  end

endmodule

// File: tb/tb_seven_segment_display_mux.sv
// Bench for seven_segment_display_mux: randomized and directed stimulus against a cycle-count
// reference model (4 digits, 4-clock slots, 3-bit brightness).
module tb_seven_segment_display_mux;
  localparam int CLK_MHZ = 1, UPDATE_HZ = 62500, W = 4, WB = 3;
  localparam int P = 4, FRAME = P * W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] number = '0;
  logic [3:0]  dots = '0;
  logic        number_valid = 1'b0;
  logic        number_ready;
  logic        blank_lz = 1'b0;
  logic [2:0]  brightness = 3'd7;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
`ifdef SEVEN_SEGMENT_DISPLAY_MUX_BLINK_EN
  logic [3:0]  blink = '0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int          n;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddots, m_pdots;
  bit          m_full;
  logic [7:0]  exp_abc;
  logic [3:0]  exp_digit;
  logic        exp_ready;
  logic [7:0]  seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  always #5 clk = ~clk;

  seven_segment_display_mux #(
    .clk_mhz(CLK_MHZ), .w_digit(W), .update_hz(UPDATE_HZ), .w_bright(WB)
  ) dut (
    .clk(clk), .rst(rst), .number(number), .dots(dots), .number_valid(number_valid),
    .number_ready(number_ready), .blank_lz(blank_lz), .brightness(brightness),
`ifdef SEVEN_SEGMENT_DISPLAY_MUX_BLINK_EN
    .blink(blink),
`endif
    .abcdefgh(abcdefgh), .digit(digit)
  );

  task automatic model_reset();
    n = 0; m_disp = '0; m_pend = '0; m_ddots = '0; m_pdots = '0; m_full = 0;
    exp_abc = 8'h00; exp_digit = 4'h0; exp_ready = 1'b1;
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    number_valid = 1'b0;
    rst = 1'b1;
  endtask

  // Advance one clock; expectations come from the edge count since reset and the update rules
  task automatic tick();
    int ip, pw;
    logic [15:0] upper;
    logic [7:0]  s;
    bit fire, xfer;
    logic [15:0] num_in;
    logic [3:0]  dots_in;
    ip = (n / P) % W;
    pw = n % 8;
    upper = m_disp >> (4 * ip);
    s = (blank_lz && ip != 0 && upper == 16'h0) ? 8'h00 : seg_tab[upper[3:0]];
    s[0] = m_ddots[ip];
    exp_abc = (pw <= int'(brightness)) ? s : 8'h00;
    exp_digit = 4'(1 << ip);
    fire = m_full && ((n + 1) % FRAME == 0);
    xfer = number_valid && !m_full;
    num_in = number;
    dots_in = dots;
    @(posedge clk);
    #1;
    n++;
    if (fire) begin m_disp = m_pend; m_ddots = m_pdots; m_full = 0; end
    if (xfer) begin m_pend = num_in; m_pdots = dots_in; m_full = 1; end
    exp_ready = !m_full;
  endtask

  task automatic seek_digit(input logic [3:0] d, output bit found);
    found = 0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      tick();
      if (digit == d) found = 1;
    end
  endtask

  task automatic send(input logic [15:0] num, input logic [3:0] dt);
    number = num; dots = dt; number_valid = 1'b1;
    tick();
    number_valid = 1'b0;
  endtask

  task automatic run_checked(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      tick();
      vectors++;
      if ({abcdefgh, digit, number_ready} !== {exp_abc, exp_digit, exp_ready}) begin
        miscompares++;
        $display("FAIL %s n=%0d got abc=%h digit=%b ready=%b, want abc=%h digit=%b ready=%b",
                 tag, n, abcdefgh, digit, number_ready, exp_abc, exp_digit, exp_ready);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] want_digit [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    number = 16'hFFFF; number_valid = 1'b1; brightness = 3'd7; blank_lz = 1'b0;
    apply_reset(5);
    vectors++;
    if (abcdefgh !== 8'h00) begin miscompares++; $display("FAIL reset_abc got %h want 00", abcdefgh); end
    vectors++;
    if (digit !== 4'b0000) begin miscompares++; $display("FAIL reset_digit got %b want 0000", digit); end
    vectors++;
    if (number_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", number_ready); end
    release_reset();
    for (int t = 0; t < 16; t++) begin
      tick();
      if (t % 4 == 0) begin
        vectors++;
        if (digit !== want_digit[t/4]) begin
          miscompares++; $display("FAIL scan_digit t=%0d got %b want %b", t, digit, want_digit[t/4]);
        end
      end
    end
    run_checked("post_reset", FRAME);
  endtask

  task automatic test_handshake();
    bit f;
    send(16'h12AF, 4'h0);
    vectors++;
    if (number_ready !== 1'b0) begin miscompares++; $display("FAIL hs_ready got %b want 0", number_ready); end
    run_checked("handshake", 2 * FRAME);
    seek_digit(4'b0001, f);
    vectors++;
    if (!f || abcdefgh !== 8'h8E) begin miscompares++; $display("FAIL hs_digit0 got %h want 8e", abcdefgh); end
    seek_digit(4'b1000, f);
    vectors++;
    if (!f || abcdefgh !== 8'h60) begin miscompares++; $display("FAIL hs_digit3 got %h want 60", abcdefgh); end
  endtask

  task automatic test_back_pressure();
    bit f;
    send(16'h12AF, 4'h0);
    number = 16'h5555; number_valid = 1'b1;
    for (int k = 0; k < 2 * FRAME && !number_ready; k++) run_checked("bp_hold", 1);
    number_valid = 1'b0;
    vectors++;
    if (number_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_timeout got %b want 1", number_ready); end
    run_checked("bp_after", FRAME + 3);
    seek_digit(4'b0001, f);
    vectors++;
    if (!f || abcdefgh !== 8'h8E) begin miscompares++; $display("FAIL bp_digit0 got %h want 8e", abcdefgh); end
  endtask

  task automatic test_blanking();
    bit f;
    logic [7:0] want [4] = '{8'hFC, 8'hF2, 8'h00, 8'h01};
    blank_lz = 1'b1;
    send(16'h0030, 4'b1000);
    run_checked("blank", 2 * FRAME);
    for (int d = 0; d < 4; d++) begin
      seek_digit(4'(1 << d), f);
      vectors++;
      if (!f || abcdefgh !== want[d]) begin
        miscompares++; $display("FAIL blank_digit%0d got %h want %h", d, abcdefgh, want[d]);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_brightness();
    int on;
    send(16'h8888, 4'h0);
    run_checked("bright_load", 2 * FRAME);
    brightness = 3'd1;
    for (int w = 0; w < 2; w++) begin
      on = 0;
      for (int k = 0; k < 8; k++) begin
        run_checked("bright1", 1);
        if (abcdefgh != 8'h00) on++;
      end
      vectors++;
      if (on != 2) begin miscompares++; $display("FAIL bright1_duty got %0d want 2", on); end
    end
    brightness = 3'd7;
    on = 0;
    for (int k = 0; k < 8; k++) begin
      run_checked("bright7", 1);
      if (abcdefgh != 8'h00) on++;
    end
    vectors++;
    if (on != 8) begin miscompares++; $display("FAIL bright7_duty got %0d want 8", on); end
  endtask

  task automatic test_reset_mid();
    bit f;
    send(16'hABCD, 4'hF);
    tick();
    apply_reset(2);
    vectors++;
    if (number_ready !== 1'b1 || digit !== 4'h0) begin
      miscompares++; $display("FAIL midreset got ready=%b digit=%b want 1/0000", number_ready, digit);
    end
    release_reset();
    run_checked("midreset", 2 * FRAME);
    seek_digit(4'b0001, f);
    vectors++;
    if (!f || abcdefgh !== 8'hFC) begin miscompares++; $display("FAIL midreset_digit0 got %h want fc", abcdefgh); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      number       = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      dots         = 4'($urandom);
      number_valid = ($urandom_range(0, 3) == 0);
      blank_lz     = 1'($urandom);
      brightness   = 3'($urandom);
      run_checked("random", 1);
    end
    number_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_handshake();
    test_back_pressure();
    test_blanking();
    test_brightness();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
